// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared sizing constants for the register file
package regfile_pkg;

    localparam int REGFILE_DATA_W    = 32;
    localparam int REGFILE_ADDR_W    = 5;
    localparam int REGFILE_REG_COUNT = 2 ** REGFILE_ADDR_W;
    localparam int REGFILE_ZERO_REG  = 0;

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - two-read one-write register file with hardwired zero register
module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int ADDR_W = REGFILE_ADDR_W
) (
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    input  logic [ADDR_W-1:0] read_reg_1,
    input  logic [ADDR_W-1:0] read_reg_2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              regWrite,
    input  logic              clk,
    input  logic              rst_n
);

    localparam int                NREGS    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REGFILE_ZERO_REG);

    logic [DATA_W-1:0] regs [NREGS];

    // Clocked write port; reset clears everything and wins over a write on the same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (regWrite && (write_reg != ZERO_IDX)) begin
            regs[write_reg] <= write_data;
        end
    end

    // Read port 1: combinational, zero register forced so it reads 0 even before any reset
    always_comb begin
        read_data_1 = '0;
        if (read_reg_1 != ZERO_IDX) begin
            read_data_1 = regs[read_reg_1];
        end
    end

    // Read port 2: independent copy of the read mux
    always_comb begin
        read_data_2 = '0;
        if (read_reg_2 != ZERO_IDX) begin
            read_data_2 = regs[read_reg_2];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - randomized self-checking bench for register_file
`timescale 1ns/1ps
module tb_register_file;

    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic [4:0]  read_reg_1;
    logic [4:0]  read_reg_2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        regWrite;
    logic        clk;
    logic        rst_n;

    int checks;
    int errors;

    logic [31:0] model [32];
    bit          model_valid;

    register_file dut (
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2),
        .read_reg_1  (read_reg_1),
        .read_reg_2  (read_reg_2),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .regWrite    (regWrite),
        .clk         (clk),
        .rst_n       (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference memory: an array of 32 words updated by the behavioural write/reset rules
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
            model_valid = 1'b1;
        end else if (regWrite && write_reg != 5'd0) begin
            model[write_reg] = write_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Per-cycle comparison of both read ports against the reference memory
    always @(negedge clk) begin
        if (model_valid) begin
            chk("port1_vs_model", read_data_1, (read_reg_1 == 5'd0) ? 32'd0 : model[read_reg_1]);
            chk("port2_vs_model", read_data_2, (read_reg_2 == 5'd0) ? 32'd0 : model[read_reg_2]);
        end else begin
            if (read_reg_1 == 5'd0) chk("pre_reset_r0_p1", read_data_1, 32'd0);
            if (read_reg_2 == 5'd0) chk("pre_reset_r0_p2", read_data_2, 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_one(input logic [4:0] idx, input logic [31:0] val);
        write_reg  = idx;
        write_data = val;
        regWrite   = 1'b1;
        step();
        regWrite   = 1'b0;
    endtask

    task automatic sweep_zero(input string name);
        for (int i = 0; i < 32; i++) begin
            read_reg_1 = 5'(i);
            read_reg_2 = 5'(31 - i);
            #1;
            chk(name, read_data_1, 32'd0);
            chk(name, read_data_2, 32'd0);
            step();
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        model_valid = 1'b0;
        rst_n       = 1'b0;
        regWrite    = 1'b0;
        write_reg   = 5'd0;
        write_data  = 32'd0;
        read_reg_1  = 5'd0;
        read_reg_2  = 5'd0;
        #1;
        chk("pre_reset_zero_reg", read_data_1, 32'd0);

        // Reset for one edge, then every index on both ports reads zero
        step();
        rst_n = 1'b1;
        sweep_zero("reset_sweep");

        // Write then read
        write_one(5'd1, 32'd55);
        read_reg_1 = 5'd0;
        read_reg_2 = 5'd1;
        #1;
        chk("write_read_r1", read_data_2, 32'd55);
        chk("write_read_r0", read_data_1, 32'd0);

        // Writes to register 0 are discarded
        write_one(5'd0, 32'hFFFF_FFFF);
        read_reg_1 = 5'd0;
        #1;
        chk("r0_protect", read_data_1, 32'd0);

        // Write enable low leaves the register alone
        write_one(5'd5, 32'h0000_A5A5);
        write_reg  = 5'd5;
        write_data = 32'hDEAD_BEEF;
        regWrite   = 1'b0;
        step();
        read_reg_1 = 5'd5;
        #1;
        chk("write_disabled", read_data_1, 32'h0000_A5A5);

        // Same-cycle read of the register being written: old value until the edge
        write_one(5'd7, 32'h0000_1111);
        read_reg_1 = 5'd7;
        write_reg  = 5'd7;
        write_data = 32'h1234_5678;
        regWrite   = 1'b1;
        #1;
        chk("same_cycle_before", read_data_1, 32'h0000_1111);
        step();
        chk("same_cycle_after", read_data_1, 32'h1234_5678);
        regWrite = 1'b0;

        // Reset pulsed between edges must not clear anything
        write_one(5'd9, 32'h0000_0099);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        read_reg_1 = 5'd9;
        #1;
        chk("no_async_reset", read_data_1, 32'h0000_0099);
        step();
        chk("no_async_reset_edge", read_data_1, 32'h0000_0099);

        // Randomized traffic checked by the per-cycle compare
        for (int n = 0; n < 2000; n++) begin
            rst_n      = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            regWrite   = ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0;
            write_reg  = 5'($urandom_range(0, 31));
            write_data = $urandom;
            read_reg_1 = 5'($urandom_range(0, 31));
            read_reg_2 = ($urandom_range(0, 3) == 0) ? read_reg_1 : 5'($urandom_range(0, 31));
            step();
        end
        rst_n    = 1'b1;
        regWrite = 1'b0;

        // Reset collides with a write: reset wins
        write_one(5'd3, 32'h0000_0033);
        rst_n      = 1'b0;
        regWrite   = 1'b1;
        write_reg  = 5'd3;
        write_data = 32'h0000_ABCD;
        step();
        rst_n    = 1'b1;
        regWrite = 1'b0;
        read_reg_1 = 5'd3;
        #1;
        chk("reset_beats_write", read_data_1, 32'd0);
        sweep_zero("collision_sweep");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter: DATA_W, 32, register and data-port width in bits.
REQ-002 Parameter: ADDR_W, 5, register-index width; register count = 2**ADDR_W = 32.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: read_reg_1  input  ADDR_W  index for read port 1.
REQ-006 Port: read_reg_2  input  ADDR_W  index for read port 2.
REQ-007 Port: write_reg  input  ADDR_W  index for the write port.
REQ-008 Port: write_data  input  DATA_W  data for the write port.
REQ-009 Port: regWrite  input  1  write enable, active-high.
REQ-010 Port: read_data_1  output  DATA_W  contents of register read_reg_1.
REQ-011 Port: read_data_2  output  DATA_W  contents of register read_reg_2.
REQ-012 Positional port order SHALL be read_data_1, read_data_2, read_reg_1, read_reg_2, write_reg, write_data, regWrite, clk, rst_n, so that existing positional instantiations bind correctly.

Function
REQ-013 Storage SHALL be 32 registers of DATA_W bits each.
REQ-014 Both read ports SHALL be combinational: each read_data_N reflects the addressed register within the same cycle, with no clock latency.
REQ-015 The two read ports SHALL be fully independent and may address the same register simultaneously.
REQ-016 On a rising clk edge with rst_n=1 and regWrite=1, register[write_reg] SHALL take the value of write_data.
REQ-017 With regWrite=0, no register SHALL change.
REQ-018 Register 0 SHALL read as zero at all times; writes to index 0 SHALL be discarded.
REQ-019 A read of the register being written in the same cycle SHALL return the old value until the clock edge, then the new value; there is no write-to-read bypass.
REQ-020 Write latency is one edge: the value is visible on the read ports immediately after the capturing edge.
REQ-021 Before the first reset, register contents are unspecified; X on the read outputs is acceptable, except that register 0 reads zero.

Reset
REQ-022 On a rising clk edge with rst_n=0, all 32 registers SHALL clear to zero.
REQ-023 Reset SHALL take priority over a simultaneous write, which is then discarded.
REQ-024 Reset SHALL NOT act asynchronously: deasserting or asserting rst_n between edges has no effect until the next edge.

Structure
REQ-025 DATA_W, ADDR_W, the register count and the zero-register index (0) SHALL live in a shared package (regfile_pkg) used by the datapath.
REQ-026 The design SHALL be a single module with no sub-modules: one storage array, one clocked write process and two combinational read muxes.

Verification
REQ-027 Reset: hold rst_n=0 for one edge, then read indices 0..31 on both ports -> every value reads 0.
REQ-028 Write then read: write_reg=1, write_data=32'd55, regWrite=1 for one edge, then regWrite=0 and read_reg_2=1 -> read_data_2=55; read_reg_1=0 -> read_data_1=0.
REQ-029 Register 0 protection: write_reg=0, write_data=32'hFFFF_FFFF, regWrite=1 for one edge -> read_data_1 for index 0 stays 0.
REQ-030 Write disabled: regWrite=0, write_reg=5, write_data=32'hDEAD_BEEF across an edge -> register 5 keeps its prior value.
REQ-031 Same-cycle read/write: read_reg_1=7 while writing 32'h1234_5678 to register 7 -> read_data_1 shows the old value before the edge and 32'h1234_5678 after it.
REQ-032 Reset/write collision: rst_n=0 and regWrite=1 to register 3 on the same edge -> register 3 reads 0, and both ports read 0 on all indices.
